// File: rtl/ukp_pad_pkg.sv
// Shared definitions for the ukp report to NES pad mapping: button bit positions,
// axis threshold decode and the serial shift order of the NES pad port.
package ukp_pad_pkg;

  localparam int BTN_A     = 0;
  localparam int BTN_B     = 1;
  localparam int BTN_SEL   = 2;
  localparam int BTN_STA   = 3;
  localparam int BTN_LEFT  = 4;
  localparam int BTN_RIGHT = 5;
  localparam int BTN_DOWN  = 6;
  localparam int BTN_UP    = 7;

  // btn_nes bit that lands in each shift register position; position 0 leaves first
  localparam logic [2:0] SER_IDX [0:7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd6, 3'd4, 3'd5};

  typedef struct packed {
    logic lo;
    logic hi;
  } axis_dir_t;

  typedef struct packed {
    logic [7:0] btn;
    logic       ta;
    logic       tb;
  } raw_state_t;

  function automatic axis_dir_t axis_decode(input logic [7:0] v,
                                            input logic [7:0] lo_th,
                                            input logic [7:0] hi_th);
    axis_dir_t d;
    d.lo = (v < lo_th) ? 1'b1 : 1'b0;
    // a misconfigured threshold pair must still never report both directions
    d.hi = ((v > hi_th) && !d.lo) ? 1'b1 : 1'b0;
    return d;
  endfunction

  function automatic logic [7:0] to_serial(input logic [7:0] btn);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      s[i] = btn[SER_IDX[i]];
    end
    return s;
  endfunction

endpackage

// File: rtl/nes_pad_shifter.sv
// NES $4016-style pad port: parallel load while latched, LSB-first shift on each
// sclk rise, ones shifted in so the line idles high once the byte is exhausted.
module nes_pad_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       latch,
  input  logic       sclk,
  input  logic [7:0] load_val,
  output logic       dout
);

  logic       sclk_q_r;
  logic [7:0] sr_r;
  logic       dout_r;
  logic       sclk_rise_s;

  assign sclk_rise_s = sclk & ~sclk_q_r;

  // latch has priority over a coincident shift clock rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q_r <= 1'b0;
      sr_r     <= 8'hFF;
      dout_r   <= 1'b1;
    end else begin
      sclk_q_r <= sclk;
      dout_r   <= sr_r[0];
      if (latch) begin
        sr_r <= load_val;
      end else if (sclk_rise_s) begin
        sr_r <= {1'b1, sr_r[7:1]};
      end else begin
        sr_r <= sr_r;
      end
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/hid_pad_mapper.sv
// USB-HID report to NES pad mapper: frame validation, axis/button decode, turbo,
// stale-report timeout, and parallel plus serial pad outputs.
module hid_pad_mapper
  import ukp_pad_pkg::*;
#(
  parameter int         AXIS_Y_IDX = 3,
  parameter int         AXIS_X_IDX = 4,
  parameter int         BTN0_IDX   = 5,
  parameter int         BTN1_IDX   = 6,
  parameter int         BIT_A      = 5,
  parameter int         BIT_B      = 6,
  parameter int         BIT_TA     = 4,
  parameter int         BIT_TB     = 7,
  parameter int         BIT_SEL    = 4,
  parameter int         BIT_STA    = 5,
  parameter logic [7:0] AXIS_LO    = 8'h40,
  parameter logic [7:0] AXIS_HI    = 8'hC0,
  parameter int         MIN_BYTES  = 7,
  parameter int         MAX_BYTES  = 11,
  parameter int         TIMEOUT    = 12000000,
  parameter int         TURBO_HALF = 200000
) (
  input  logic       usbclk,
  input  logic       usbrst_n,
  input  logic       rpt_rdy,
  input  logic       rpt_stb,
  input  logic [7:0] rpt_dat,
  input  logic       turbo_en,
  input  logic       pad_latch,
  input  logic       pad_clk,
  output logic       pad_dout,
  output logic [7:0] btn_nes,
  output logic       btn_upd,
  output logic       rpt_err,
  output logic       stale
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int PH_W  = $clog2(TURBO_HALF + 1);

  logic             rdy_q_r;
  logic             stb_q_r;
  logic             act_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic [7:0]       shd_y_r;
  logic [7:0]       shd_x_r;
  logic [7:0]       shd_b0_r;
  logic [7:0]       shd_b1_r;
  raw_state_t       raw_r;
  logic [TMO_W-1:0] tmo_r;
  logic             stale_r;
  logic             upd_r;
  logic             err_r;
  logic [PH_W-1:0]  ph_cnt_r;
  logic             phase_r;
  logic [7:0]       btn_r;

  logic             rdy_rise_s;
  logic             rdy_fall_s;
  logic             stb_rise_s;
  logic             frame_ok_s;
  logic             commit_s;
  logic             reject_s;
  logic             tmo_hit_s;
  axis_dir_t        dy_s;
  axis_dir_t        dx_s;
  raw_state_t       dec_s;
  logic [7:0]       btn_next_s;
  logic [7:0]       ser_s;

  assign rdy_rise_s = rpt_rdy & ~rdy_q_r;
  assign rdy_fall_s = ~rpt_rdy & rdy_q_r;
  assign stb_rise_s = rpt_stb & ~stb_q_r;
  assign frame_ok_s = (cnt_r >= CNT_W'(MIN_BYTES)) & ~ovf_r;
  // act_r gates commit so a frame already open across reset release is discarded
  assign commit_s   = rdy_fall_s & act_r & frame_ok_s;
  assign reject_s   = rdy_fall_s & act_r & ~frame_ok_s;
  assign tmo_hit_s  = (tmo_r == TMO_W'(TIMEOUT - 1));

  // byte counting and shadow capture of the fields of interest
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      rdy_q_r  <= 1'b1;
      stb_q_r  <= 1'b0;
      act_r    <= 1'b0;
      cnt_r    <= '0;
      ovf_r    <= 1'b0;
      shd_y_r  <= 8'h00;
      shd_x_r  <= 8'h00;
      shd_b0_r <= 8'h00;
      shd_b1_r <= 8'h00;
    end else begin
      rdy_q_r <= rpt_rdy;
      stb_q_r <= rpt_stb;
      if (rdy_rise_s) begin
        act_r <= 1'b1;
        cnt_r <= '0;
        ovf_r <= 1'b0;
      end else if (rdy_fall_s) begin
        act_r <= 1'b0;
      end else if (stb_rise_s && rpt_rdy) begin
        if (cnt_r == CNT_W'(MAX_BYTES)) begin
          ovf_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
        if (cnt_r == CNT_W'(AXIS_Y_IDX)) shd_y_r  <= rpt_dat;
        if (cnt_r == CNT_W'(AXIS_X_IDX)) shd_x_r  <= rpt_dat;
        if (cnt_r == CNT_W'(BTN0_IDX))   shd_b0_r <= rpt_dat;
        if (cnt_r == CNT_W'(BTN1_IDX))   shd_b1_r <= rpt_dat;
      end
    end
  end

  // shadow fields to button state
  always_comb begin
    dy_s              = axis_decode(shd_y_r, AXIS_LO, AXIS_HI);
    dx_s              = axis_decode(shd_x_r, AXIS_LO, AXIS_HI);
    dec_s             = '0;
    dec_s.btn[BTN_UP]    = dy_s.lo;
    dec_s.btn[BTN_DOWN]  = dy_s.hi;
    dec_s.btn[BTN_LEFT]  = dx_s.lo;
    dec_s.btn[BTN_RIGHT] = dx_s.hi;
    dec_s.btn[BTN_STA]   = shd_b1_r[BIT_STA];
    dec_s.btn[BTN_SEL]   = shd_b1_r[BIT_SEL];
    dec_s.btn[BTN_B]     = shd_b0_r[BIT_B];
    dec_s.btn[BTN_A]     = shd_b0_r[BIT_A];
    dec_s.ta             = shd_b0_r[BIT_TA];
    dec_s.tb             = shd_b0_r[BIT_TB];
  end

  // commit/reject, stale timeout; a commit beats a timeout in the same cycle
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      raw_r   <= '0;
      tmo_r   <= '0;
      stale_r <= 1'b1;
      upd_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      upd_r <= commit_s;
      err_r <= reject_s;
      if (commit_s) begin
        raw_r   <= dec_s;
        tmo_r   <= '0;
        stale_r <= 1'b0;
      end else if (tmo_hit_s) begin
        raw_r   <= '0;
        stale_r <= 1'b1;
      end else begin
        tmo_r <= tmo_r + TMO_W'(1);
      end
    end
  end

  // free-running turbo phase
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      ph_cnt_r <= '0;
      phase_r  <= 1'b0;
    end else if (ph_cnt_r == PH_W'(TURBO_HALF - 1)) begin
      ph_cnt_r <= '0;
      phase_r  <= ~phase_r;
    end else begin
      ph_cnt_r <= ph_cnt_r + PH_W'(1);
    end
  end

  // turbo merge onto A/B
  always_comb begin
    btn_next_s        = raw_r.btn;
    btn_next_s[BTN_A] = raw_r.btn[BTN_A] | (turbo_en & raw_r.ta & phase_r);
    btn_next_s[BTN_B] = raw_r.btn[BTN_B] | (turbo_en & raw_r.tb & phase_r);
  end

  // registered parallel pad vector
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      btn_r <= 8'h00;
    end else begin
      btn_r <= btn_next_s;
    end
  end

  assign ser_s = to_serial(btn_r);

  nes_pad_shifter u_shifter (
    .clk      (usbclk),
    .rst_n    (usbrst_n),
    .latch    (pad_latch),
    .sclk     (pad_clk),
    .load_val (ser_s),
    .dout     (pad_dout)
  );

  assign btn_nes = btn_r;
  assign btn_upd = upd_r;
  assign rpt_err = err_r;
  assign stale   = stale_r;

endmodule

// File: tb/tb_hid_pad_mapper.sv
// Directed bench for hid_pad_mapper with a frame-level reference model and
// per-cycle comparison of the parallel outputs.
module tb_hid_pad_mapper;

  localparam int TMO = 400;
  localparam int TH  = 16;
  localparam int SER_ORD [8] = '{0, 1, 2, 3, 7, 6, 4, 5};

  logic       usbclk    = 1'b0;
  logic       usbrst_n  = 1'b0;
  logic       rpt_rdy   = 1'b0;
  logic       rpt_stb   = 1'b0;
  logic [7:0] rpt_dat   = 8'h00;
  logic       turbo_en  = 1'b0;
  logic       pad_latch = 1'b0;
  logic       pad_clk   = 1'b0;
  logic       pad_dout;
  logic [7:0] btn_nes;
  logic       btn_upd;
  logic       rpt_err;
  logic       stale;

  int n_chk  = 0;
  int n_pass = 0;
  int upd_seen = 0;
  int err_seen = 0;

  // reference model state
  logic [7:0] m_bytes[$];
  logic       m_open = 1'b0;
  logic       m_prev_rdy = 1'b1;
  logic       m_prev_stb = 1'b0;
  logic [7:0] m_raw = 8'h00;
  logic       m_ta = 1'b0;
  logic       m_tb = 1'b0;
  logic [7:0] m_btn = 8'h00;
  logic       m_upd = 1'b0;
  logic       m_err = 1'b0;
  logic       m_stale = 1'b1;
  int         m_since = 0;
  int         m_cyc = 0;

  hid_pad_mapper #(.TIMEOUT(TMO), .TURBO_HALF(TH)) dut (
    .usbclk    (usbclk),
    .usbrst_n  (usbrst_n),
    .rpt_rdy   (rpt_rdy),
    .rpt_stb   (rpt_stb),
    .rpt_dat   (rpt_dat),
    .turbo_en  (turbo_en),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .pad_dout  (pad_dout),
    .btn_nes   (btn_nes),
    .btn_upd   (btn_upd),
    .rpt_err   (rpt_err),
    .stale     (stale)
  );

  always #5 usbclk = ~usbclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] frame_btn(input logic [7:0] y, input logic [7:0] x,
                                           input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] r;
    r = 8'h00;
    if (y < 8'h40) r = r | 8'h80;
    else if (y > 8'hC0) r = r | 8'h40;
    if (x < 8'h40) r = r | 8'h10;
    else if (x > 8'hC0) r = r | 8'h20;
    if (b1[5]) r = r | 8'h08;
    if (b1[4]) r = r | 8'h04;
    if (b0[6]) r = r | 8'h02;
    if (b0[5]) r = r | 8'h01;
    return r;
  endfunction

  function automatic logic ser_exp(input logic [7:0] b, input int pos);
    if (pos >= 8) return 1'b1;
    return b[SER_ORD[pos]];
  endfunction

  task automatic model_reset();
    m_bytes.delete();
    m_open = 1'b0; m_prev_rdy = 1'b1; m_prev_stb = 1'b0;
    m_raw = 8'h00; m_ta = 1'b0; m_tb = 1'b0; m_btn = 8'h00;
    m_upd = 1'b0; m_err = 1'b0; m_stale = 1'b1; m_since = 0; m_cyc = 0;
  endtask

  task automatic model_step();
    logic rise, fall, srise, commit, ph;
    logic [7:0] nb;
    ph = ((m_cyc / TH) % 2) == 1;
    nb = m_raw;
    if (turbo_en && m_ta && ph) nb[0] = 1'b1;
    if (turbo_en && m_tb && ph) nb[1] = 1'b1;
    m_btn  = nb;
    rise   = rpt_rdy && !m_prev_rdy;
    fall   = !rpt_rdy && m_prev_rdy;
    srise  = rpt_stb && !m_prev_stb;
    m_upd  = 1'b0;
    m_err  = 1'b0;
    commit = 1'b0;
    if (rise) begin
      m_bytes.delete();
      m_open = 1'b1;
    end else if (fall) begin
      if (m_open) begin
        if (m_bytes.size() >= 7 && m_bytes.size() <= 11) begin
          commit  = 1'b1;
          m_raw   = frame_btn(m_bytes[3], m_bytes[4], m_bytes[5], m_bytes[6]);
          m_ta    = m_bytes[5][4];
          m_tb    = m_bytes[5][7];
          m_upd   = 1'b1;
          m_stale = 1'b0;
          m_since = 0;
        end else begin
          m_err = 1'b1;
        end
      end
      m_open = 1'b0;
    end else if (srise && rpt_rdy) begin
      m_bytes.push_back(rpt_dat);
    end
    if (!commit) begin
      if (m_since < TMO) m_since++;
      if (m_since >= TMO) begin
        m_raw = 8'h00; m_ta = 1'b0; m_tb = 1'b0; m_stale = 1'b1;
      end
    end
    m_cyc++;
    m_prev_rdy = rpt_rdy;
    m_prev_stb = rpt_stb;
  endtask

  initial begin
    forever begin
      @(posedge usbclk or negedge usbrst_n);
      if (!usbrst_n) model_reset();
      else model_step();
    end
  end

  // every-cycle comparison of the parallel outputs against the model
  initial begin
    forever begin
      @(negedge usbclk);
      if (usbrst_n) begin
        check("btn_nes", btn_nes, m_btn);
        check("btn_upd", btn_upd, m_upd);
        check("rpt_err", rpt_err, m_err);
        check("stale",   stale,   m_stale);
        if (btn_upd) upd_seen++;
        if (rpt_err) err_seen++;
      end
    end
  end

  task automatic send_bytes(input int n, input logic [7:0] y, input logic [7:0] x,
                            input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < n; i++) begin
      case (i)
        3:       rpt_dat = y;
        4:       rpt_dat = x;
        5:       rpt_dat = b0;
        6:       rpt_dat = b1;
        default: rpt_dat = 8'hA0 + 8'(i);
      endcase
      rpt_stb = 1'b1;
      @(negedge usbclk);
      rpt_stb = 1'b0;
      @(negedge usbclk);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] y, input logic [7:0] x,
                            input logic [7:0] b0, input logic [7:0] b1);
    @(negedge usbclk);
    rpt_rdy = 1'b1;
    @(negedge usbclk);
    send_bytes(n, y, x, b0, b1);
    rpt_rdy = 1'b0;
    repeat (3) @(negedge usbclk);
  endtask

  task automatic pad_rise();
    pad_clk = 1'b1;
    @(negedge usbclk);
    pad_clk = 1'b0;
    repeat (2) @(negedge usbclk);
  endtask

  task automatic pad_load(input logic with_clk);
    pad_latch = 1'b1;
    pad_clk   = with_clk;
    @(negedge usbclk);
    pad_latch = 1'b0;
    pad_clk   = 1'b0;
    repeat (2) @(negedge usbclk);
  endtask

  initial begin
    int u0, e0, tog;
    logic a0, a1;
    logic [9:0] seq81;
    logic [7:0] snap;
    seq81 = 10'h311;

    repeat (3) @(negedge usbclk);
    usbrst_n = 1'b1;
    @(negedge usbclk);
    check("rst_btn", btn_nes, 8'h00);
    check("rst_stale", stale, 1'b1);
    check("rst_dout", pad_dout, 1'b1);
    check("rst_upd", btn_upd, 1'b0);

    // basic decode
    u0 = upd_seen;
    send_frame(8, 8'h00, 8'hFF, 8'h20, 8'h20);
    check("t1_btn", btn_nes, 8'hA9);
    check("t1_upd_pulses", upd_seen - u0, 1);
    check("t1_stale", stale, 1'b0);

    // length errors
    e0 = err_seen;
    send_frame(6, 8'h80, 8'h80, 8'h00, 8'h00);
    check("short_err", err_seen - e0, 1);
    check("short_hold", btn_nes, 8'hA9);
    send_frame(12, 8'h80, 8'h80, 8'h00, 8'h00);
    check("ovf_err", err_seen - e0, 2);
    check("ovf_hold", btn_nes, 8'hA9);

    // axis thresholds, min and max frame lengths
    send_frame(7, 8'h40, 8'hC0, 8'h00, 8'h00);
    check("axis_edge", btn_nes, 8'h00);
    send_frame(11, 8'h3F, 8'h80, 8'h00, 8'h00);
    check("axis_up", btn_nes, 8'h80);
    send_frame(8, 8'hC1, 8'h3F, 8'h40, 8'h10);
    check("axis_down", btn_nes, 8'h56);

    // serial readout of 8'h56, latch+clk reload
    pad_load(1'b0);
    check("ser56_p0", pad_dout, ser_exp(m_btn, 0));
    pad_rise();
    check("ser56_p1", pad_dout, ser_exp(m_btn, 1));
    pad_load(1'b1);
    check("ser_reload", pad_dout, 1'b0);
    for (int i = 1; i < 10; i++) begin
      pad_rise();
      check($sformatf("ser56_p%0d", i), pad_dout, ser_exp(m_btn, i));
    end

    // stale timeout
    repeat (TMO + 5) @(negedge usbclk);
    check("tmo_btn", btn_nes, 8'h00);
    check("tmo_stale", stale, 1'b1);

    // serial readout of 8'h81
    send_frame(8, 8'h00, 8'h80, 8'h20, 8'h00);
    check("tmo_clear", stale, 1'b0);
    check("ser81_btn", btn_nes, 8'h81);
    pad_load(1'b0);
    check("ser81_p0", pad_dout, seq81[0]);
    for (int i = 1; i < 10; i++) begin
      pad_rise();
      check($sformatf("ser81_p%0d", i), pad_dout, seq81[i]);
    end

    // turbo A
    turbo_en = 1'b1;
    send_frame(8, 8'h80, 8'h80, 8'h10, 8'h00);
    a0 = btn_nes[0];
    repeat (TH) @(negedge usbclk);
    a1 = btn_nes[0];
    check("turbo_half1", a0 ^ a1, 1'b1);
    repeat (TH) @(negedge usbclk);
    check("turbo_period", btn_nes[0], a0);
    tog = 0;
    snap = btn_nes;
    for (int i = 0; i < 4 * TH; i++) begin
      @(negedge usbclk);
      if (btn_nes[0] != snap[0]) tog++;
      snap = btn_nes;
    end
    check("turbo_toggles", tog, 4);
    turbo_en = 1'b0;
    repeat (2) @(negedge usbclk);
    check("turbo_off", btn_nes, 8'h00);

    // reset during an open frame discards it
    u0 = upd_seen;
    e0 = err_seen;
    @(negedge usbclk);
    rpt_rdy = 1'b1;
    @(negedge usbclk);
    send_bytes(4, 8'h00, 8'h00, 8'h20, 8'h20);
    usbrst_n = 1'b0;
    repeat (3) @(negedge usbclk);
    usbrst_n = 1'b1;
    send_bytes(4, 8'h00, 8'h00, 8'h20, 8'h20);
    rpt_rdy = 1'b0;
    repeat (3) @(negedge usbclk);
    check("midrst_upd", upd_seen - u0, 0);
    check("midrst_btn", btn_nes, 8'h00);
    check("midrst_stale", stale, 1'b1);
    send_frame(8, 8'hFF, 8'h00, 8'h40, 8'h20);
    check("postrst_btn", btn_nes, 8'h5A);
    check("postrst_upd", upd_seen - u0, 1);

    repeat (4) @(negedge usbclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
